// File: rtl/phyreg_file_param.sv
// phyreg_file_param: multi-port physical register file with ready scoreboard,
// full write-to-read bypass, optional registered read and sticky write-conflict flag.
module phyreg_file_param #(
  parameter int PRF_NUM    = 64,
  parameter int PRF_WIDTH  = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 6,
  parameter int NUM_WR     = 4,
  parameter int NUM_ALLOC  = 2,
  parameter int READ_REG   = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_RD*PRF_WIDTH-1:0]     rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_RD-1:0]               rd_ready,
  input  logic [NUM_WR-1:0]               wr_en,
  input  logic [NUM_WR*PRF_WIDTH-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]    wr_data,
  input  logic [NUM_ALLOC-1:0]            alloc_en,
  input  logic [NUM_ALLOC*PRF_WIDTH-1:0]  alloc_addr,
  output logic                            wr_conflict,
  output logic [PRF_NUM-1:0]              ready_vec,
  output logic [PRF_NUM*DATA_WIDTH-1:0]   prf_debug
);
  logic [DATA_WIDTH-1:0] mem_q [PRF_NUM];
  logic [DATA_WIDTH-1:0] mem_d [PRF_NUM];
  logic [PRF_NUM-1:0] ready_q, ready_d;
  logic conflict_q, conflict_d;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0] rd_ready_q, rd_ready_d;
  logic [PRF_WIDTH-1:0] ra;

  // nonzero and inside the physical register range
  function automatic logic live(input logic [PRF_WIDTH-1:0] a);
    return a != '0 && 32'(a) < PRF_NUM;
  endfunction

  always_comb begin
    mem_d = mem_q;
    ready_d = ready_q;
    conflict_d = conflict_q;
    for (int w = 0; w < NUM_WR; w++)
      if (wr_en[w] && live(wr_addr[w*PRF_WIDTH +: PRF_WIDTH])) begin
        mem_d[wr_addr[w*PRF_WIDTH +: PRF_WIDTH]] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        ready_d[wr_addr[w*PRF_WIDTH +: PRF_WIDTH]] = 1'b1;
      end
    // allocation after writes so a new producer leaves the register not-ready
    for (int a = 0; a < NUM_ALLOC; a++)
      if (alloc_en[a] && live(alloc_addr[a*PRF_WIDTH +: PRF_WIDTH]))
        ready_d[alloc_addr[a*PRF_WIDTH +: PRF_WIDTH]] = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (wr_en[i] && wr_en[j] && wr_addr[i*PRF_WIDTH +: PRF_WIDTH] != '0 &&
            wr_addr[i*PRF_WIDTH +: PRF_WIDTH] == wr_addr[j*PRF_WIDTH +: PRF_WIDTH])
          conflict_d = 1'b1;
    if (reset) begin
      for (int i = 0; i < PRF_NUM; i++) mem_d[i] = '0;
      ready_d = '1;
      conflict_d = 1'b0;
    end
  end

  always_comb begin
    ra = '0;
    rd_data_d = '0;
    rd_ready_d = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      ra = rd_addr[r*PRF_WIDTH +: PRF_WIDTH];
      rd_data_d[r*DATA_WIDTH +: DATA_WIDTH] = live(ra) ? mem_q[ra] : '0;
      rd_ready_d[r] = ra == '0 || (live(ra) && ready_q[ra]);
      for (int w = 0; w < NUM_WR; w++)
        if (wr_en[w] && live(ra) && wr_addr[w*PRF_WIDTH +: PRF_WIDTH] == ra) begin
          rd_data_d[r*DATA_WIDTH +: DATA_WIDTH] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
          rd_ready_d[r] = 1'b1;
        end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    ready_q <= ready_d;
    conflict_q <= conflict_d;
    rd_data_q <= reset ? '0 : rd_data_d;
    rd_ready_q <= reset ? '1 : rd_ready_d;
  end

  assign rd_data = READ_REG != 0 ? rd_data_q : rd_data_d;
  assign rd_ready = READ_REG != 0 ? rd_ready_q : rd_ready_d;
  assign wr_conflict = conflict_q;
  assign ready_vec = ready_q;

  for (genvar i = 0; i < PRF_NUM; i++) begin : g_dbg
    assign prf_debug[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
  end
endmodule

// File: tb/tb_phyreg_file_param.sv
// tb_phyreg_file_param: directed scoreboard bench driving a combinational-read
// and a registered-read instance with identical stimulus.
module tb_phyreg_file_param;
  logic clk = 1'b0;
  logic reset;
  logic [35:0] rd_addr;
  logic [3:0] wr_en;
  logic [23:0] wr_addr;
  logic [127:0] wr_data;
  logic [1:0] alloc_en;
  logic [11:0] alloc_addr;
  logic [191:0] rd_data, rd_data_r;
  logic [5:0] rd_ready, rd_ready_r;
  logic wr_conflict, wr_conflict_r;
  logic [63:0] ready_vec, ready_vec_r;
  logic [2047:0] prf_debug, prf_debug_r;
  int checks = 0;
  int errors = 0;

  typedef struct {string tag; logic [63:0] exp;} sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  phyreg_file_param #(.READ_REG(0)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .wr_conflict(wr_conflict), .ready_vec(ready_vec),
    .prf_debug(prf_debug)
  );

  phyreg_file_param #(.READ_REG(1)) dut_r (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_r), .rd_ready(rd_ready_r),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .wr_conflict(wr_conflict_r), .ready_vec(ready_vec_r),
    .prf_debug(prf_debug_r)
  );

  function automatic logic [63:0] rdd(int p);
    return 64'(rd_data[p*32 +: 32]);
  endfunction

  function automatic logic [63:0] rdd_r(int p);
    return 64'(rd_data_r[p*32 +: 32]);
  endfunction

  function automatic logic [63:0] dbg(int i);
    return 64'(prf_debug[i*32 +: 32]);
  endfunction

  task automatic push(string t, logic [63:0] e);
    sb_q.push_back('{t, e});
  endtask

  task automatic chk(logic [63:0] obs);
    sb_t s;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected nothing", obs);
    end else begin
      s = sb_q.pop_front();
      assert (obs === s.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic clr;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    alloc_en = '0;
    alloc_addr = '0;
    rd_addr = '0;
  endtask

  task automatic wr(int p, int a, logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*6 +: 6] = 6'(a);
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic al(int p, int a);
    alloc_en[p] = 1'b1;
    alloc_addr[p*6 +: 6] = 6'(a);
  endtask

  task automatic rd(int p, int a);
    rd_addr[p*6 +: 6] = 6'(a);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int p = 0; p < 6; p++) rd(p, p + 10);
    #1;
    push("rst_debug_zero", 64'd0);       chk(64'(|prf_debug));
    push("rst_ready_vec", '1);           chk(ready_vec);
    push("rst_conflict", 64'd0);         chk(64'(wr_conflict));
    push("rst_rd_data", 64'd0);          chk(64'(|rd_data));
    push("rst_rd_ready", 64'h3f);        chk(64'(rd_ready));
    push("rst_rd_data_reg", 64'd0);      chk(64'(|rd_data_r));
    push("rst_rd_ready_reg", 64'h3f);    chk(64'(rd_ready_r));

    clr();
    wr(3, 17, 32'hDEADBEEF);
    rd(5, 17);
    #1;
    push("bypass_data", 64'hDEADBEEF);   chk(rdd(5));
    push("bypass_ready", 64'd1);         chk(64'(rd_ready[5]));
    push("bypass_pre_array", 64'd0);     chk(dbg(17));
    push("bypass_array", 64'hDEADBEEF);
    push("bypass_ready_vec", 64'd1);
    push("regread_bypass", 64'hDEADBEEF);
    tick();
    clr();
    #1;
    chk(dbg(17));
    chk(64'(ready_vec[17]));
    chk(rdd_r(5));

    for (int p = 0; p < 4; p++) wr(p, 0, 32'hFFFFFFFF);
    al(0, 0);
    al(1, 0);
    rd(0, 0);
    #1;
    push("zero_data", 64'd0);            chk(rdd(0));
    push("zero_ready", 64'd1);           chk(64'(rd_ready[0]));
    push("zero_array", 64'd0);
    push("zero_ready_vec", 64'd1);
    push("zero_conflict", 64'd0);
    push("zero_reg_data", 64'd0);
    tick();
    clr();
    #1;
    chk(dbg(0));
    chk(64'(ready_vec[0]));
    chk(64'(wr_conflict));
    chk(rdd_r(0));

    al(0, 5);
    rd(2, 5);
    #1;
    push("alloc_same_cycle_ready", 64'd1); chk(64'(rd_ready[2]));
    push("alloc_ready_vec", 64'd0);
    push("alloc_rd_ready", 64'd0);
    push("alloc_reg_ready_sampled", 64'd1);
    tick();
    clr();
    rd(2, 5);
    #1;
    chk(64'(ready_vec[5]));
    chk(64'(rd_ready[2]));
    chk(64'(rd_ready_r[2]));

    wr(0, 5, 32'h55);
    #1;
    push("wb_bypass_ready", 64'd1);      chk(64'(rd_ready[2]));
    push("wb_bypass_data", 64'h55);      chk(rdd(2));
    push("wb_ready_vec", 64'd1);
    push("wb_array", 64'h55);
    tick();
    clr();
    #1;
    chk(64'(ready_vec[5]));
    chk(dbg(5));

    al(1, 6);
    wr(1, 6, 32'h66);
    rd(3, 6);
    #1;
    push("aw_bypass_ready", 64'd1);      chk(64'(rd_ready[3]));
    push("aw_bypass_data", 64'h66);      chk(rdd(3));
    push("aw_array", 64'h66);
    push("aw_ready_vec", 64'd0);
    push("aw_rd_ready", 64'd0);
    push("aw_rd_data", 64'h66);
    tick();
    clr();
    rd(3, 6);
    #1;
    chk(dbg(6));
    chk(64'(ready_vec[6]));
    chk(64'(rd_ready[3]));
    chk(rdd(3));

    clr();
    wr(1, 9, 32'h11);
    wr(2, 9, 32'h22);
    rd(1, 9);
    #1;
    push("coll_bypass_prio", 64'h22);    chk(rdd(1));
    push("coll_flag_pre", 64'd0);        chk(64'(wr_conflict));
    push("coll_array", 64'h22);
    push("coll_flag", 64'd1);
    push("coll_flag_reg_inst", 64'd1);
    tick();
    clr();
    #1;
    chk(dbg(9));
    chk(64'(wr_conflict));
    chk(64'(wr_conflict_r));
    push("coll_flag_sticky", 64'd1);
    tick();
    chk(64'(wr_conflict));

    wr(0, 3, 32'hA5);
    rd(4, 3);
    push("reg_read_t1", 64'hA5);
    push("reg_read_ready", 64'd1);
    tick();
    clr();
    #1;
    chk(rdd_r(4));
    chk(64'(rd_ready_r[4]));

    reset = 1'b1;
    wr(0, 4, 32'h44);
    rd(4, 4);
    push("rst_mid_p4", 64'd0);
    push("rst_mid_p3", 64'd0);
    push("rst_mid_conflict", 64'd0);
    push("rst_mid_ready_vec", '1);
    push("rst_mid_reg_data", 64'd0);
    push("rst_mid_reg_ready", 64'h3f);
    tick();
    reset = 1'b0;
    clr();
    #1;
    chk(64'(prf_debug_r[4*32 +: 32]));
    chk(dbg(3));
    chk(64'(wr_conflict));
    chk(ready_vec_r);
    chk(64'(|rd_data_r));
    chk(64'(rd_ready_r));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
